// File: rtl/eeprom_ctrl_pkg.sv
// Shared types and defaults for the parallel EEPROM controller.
// Latency: n/a (types, constants and a load-value helper only).
// Backpressure: n/a.
package eeprom_ctrl_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 32;

  localparam int DEF_READ_WAIT  = 4;
  localparam int DEF_WE_PULSE   = 3;
  localparam int DEF_WRITE_WAIT = 10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_WR_WAIT,
    ST_RESP
  } state_t;

  // A state lasting N cycles loads N-1 and leaves on the zero cycle; 0 behaves as 1.
  function automatic logic [CNT_W-1:0] cycles_to_load(input int unsigned cycles);
    if (cycles <= 1) return '0;
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/eeprom_ctrl_wait_counter.sv
// Loadable down-counter shared by every timed state; saturates at zero.
// Latency: load visible the cycle after load; zero flag is combinational.
// Backpressure: none; decrement requests at zero are ignored.
module wait_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/eeprom_ctrl.sv
// Byte read/write controller for a parallel EEPROM; EEPROM_DATA_POLL_EN enables bit-7 write polling.
// Latency: read READ_WAIT+1 cycles; write WE_PULSE+3+wait cycles (fixed wait or poll).
// Backpressure: req_ready only in IDLE; one request outstanding, rsp_valid is a single-cycle pulse.
module eeprom_ctrl
  import eeprom_ctrl_pkg::*;
#(
  parameter int READ_WAIT  = DEF_READ_WAIT,
  parameter int WE_PULSE   = DEF_WE_PULSE,
  parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] mem_addr,
  inout  logic [DATA_W-1:0] mem_data,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  localparam logic [CNT_W-1:0] RD_LD = cycles_to_load(READ_WAIT);
  localparam logic [CNT_W-1:0] WE_LD = cycles_to_load(WE_PULSE);
  localparam logic [CNT_W-1:0] WW_LD = cycles_to_load(WRITE_WAIT);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              timeout_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  logic latch_req;
  logic sample_rd;
  logic clear_rd;
  logic end_timeout;
  logic drive;

`ifdef EEPROM_DATA_POLL_EN
  logic [CNT_W-1:0] poll_cnt_q;
  logic             poll_gap_q;
`endif

  wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign req_ready   = (state_q == ST_IDLE) && !rst;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_timeout = rsp_valid && timeout_q;
  assign rsp_rdata   = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_data    = drive ? wdata_q : {DATA_W{1'bz}};

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    latch_req   = 1'b0;
    sample_rd   = 1'b0;
    clear_rd    = 1'b0;
    end_timeout = 1'b0;
    drive       = 1'b0;
    mem_ce_n    = 1'b1;
    mem_oe_n    = 1'b1;
    mem_we_n    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          latch_req = 1'b1;
          if (req_write) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d  = ST_RD;
            cnt_load = 1'b1;
            cnt_val  = RD_LD;
          end
        end
      end
      ST_RD: begin
        mem_ce_n = 1'b0;
        mem_oe_n = 1'b0;
        cnt_dec  = 1'b1;
        if (cnt_zero) begin
          sample_rd = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_WR_SETUP: begin
        mem_ce_n = 1'b0;
        drive    = 1'b1;
        state_d  = ST_WR_PULSE;
        cnt_load = 1'b1;
        cnt_val  = WE_LD;
      end
      ST_WR_PULSE: begin
        mem_ce_n = 1'b0;
        mem_we_n = 1'b0;
        drive    = 1'b1;
        cnt_dec  = 1'b1;
        if (cnt_zero) state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        mem_ce_n = 1'b0;
        drive    = 1'b1;
        state_d  = ST_WR_WAIT;
        cnt_load = 1'b1;
        cnt_val  = WW_LD;
      end
      ST_WR_WAIT: begin
        cnt_dec = 1'b1;
`ifdef EEPROM_DATA_POLL_EN
        // Success on the sample cycle wins over a timeout expiring in the same cycle.
        mem_ce_n = 1'b0;
        mem_oe_n = poll_gap_q;
        if (!poll_gap_q && (poll_cnt_q == '0) && (mem_data[7] == wdata_q[7])) begin
          state_d  = ST_RESP;
          clear_rd = 1'b1;
        end else if (cnt_zero) begin
          state_d     = ST_RESP;
          clear_rd    = 1'b1;
          end_timeout = 1'b1;
        end
`else
        if (cnt_zero) begin
          state_d  = ST_RESP;
          clear_rd = 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (sample_rd) begin
        rdata_q <= mem_data;
      end else if (clear_rd) begin
        rdata_q <= '0;
      end
      if (sample_rd || clear_rd) timeout_q <= end_timeout;
    end
  end

`ifdef EEPROM_DATA_POLL_EN
  // Poll sequencing: READ_WAIT cycles with OE low, then one OE-high gap, repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt_q <= '0;
      poll_gap_q <= 1'b0;
    end else if (state_q == ST_WR_HOLD) begin
      poll_cnt_q <= RD_LD;
      poll_gap_q <= 1'b0;
    end else if (state_q == ST_WR_WAIT) begin
      if (poll_gap_q) begin
        poll_gap_q <= 1'b0;
        poll_cnt_q <= RD_LD;
      end else if (poll_cnt_q == '0) begin
        poll_gap_q <= 1'b1;
      end else begin
        poll_cnt_q <= poll_cnt_q - 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Randomized scoreboard bench for eeprom_ctrl with a behavioural EEPROM and reference memory.
// Bus has a weak pull-up so a released bus reads 8'hFF; write data avoids 8'hFF.
module tb_eeprom_ctrl;
  import eeprom_ctrl_pkg::*;

  localparam int RW = 4;
  localparam int WP = 3;
`ifdef EEPROM_DATA_POLL_EN
  localparam int WW = 100;
`else
  localparam int WW = 20;
`endif
  localparam int POLL_BUSY = 50;
  localparam int RD_LAT = RW + 1;
  localparam int WR_LAT = WP + WW + 3;
`ifdef EEPROM_DATA_POLL_EN
  localparam int WR_OK_LAT = -1;
`else
  localparam int WR_OK_LAT = WR_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [14:0] mem_addr;
  wire  [7:0]  mem_data;
  logic        mem_ce_n, mem_oe_n, mem_we_n;

  logic [7:0] mem     [0:32767];
  logic [7:0] ref_mem [0:32767];
  logic [7:0] model_rd;
  int         cyc = 0;
  int         busy_until = 0;
  logic       stuck = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] last_wdata = 8'h00;

  typedef struct {
    logic [7:0] rdata;
    logic       timeout;
    int         lat;
    int         hs;
  } exp_t;
  exp_t q[$];

  eeprom_ctrl #(.READ_WAIT(RW), .WE_PULSE(WP), .WRITE_WAIT(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ce_n    (mem_ce_n),
    .mem_oe_n    (mem_oe_n),
    .mem_we_n    (mem_we_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (mem_data[gi]);
  end

  function automatic logic [7:0] init_byte(input int i);
    if (i == 32'h1234) return 8'hA5;
    return 8'((i * 73) ^ (i >> 5) ^ 8'h5A);
  endfunction

  // EEPROM model: outputs while CE/OE low, latches data on WE rising edge.
  assign model_rd = (stuck || (cyc < busy_until)) ? {~mem[mem_addr][7], mem[mem_addr][6:0]}
                                                  : mem[mem_addr];
  assign mem_data = (!mem_ce_n && !mem_oe_n) ? model_rd : 8'hzz;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = init_byte(i);
    forever begin
      @(posedge mem_we_n);
      if (!rst && !mem_ce_n) begin
        mem[mem_addr] = mem_data;
`ifdef EEPROM_DATA_POLL_EN
        busy_until = cyc + POLL_BUSY;
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: scoreboard pops plus bus invariants, sampled mid-cycle.
  int         we_run = 0;
  int         drv_run = 0;
  logic [7:0] last_rsp = 8'h00;
  logic       drv_now;
  exp_t       m_e;

  always @(negedge clk) begin
    if (rst) begin
      we_run   = 0;
      drv_run  = 0;
      last_rsp = 8'h00;
    end else begin
      chk("oe_we_exclusive", 32'((!mem_oe_n && !mem_we_n) ? 1 : 0), 32'd0);
      if (!mem_oe_n) chk("no_contention", 32'(mem_data), 32'(model_rd));
      drv_now = mem_oe_n && (mem_data !== 8'hFF);
      if (drv_now) drv_run++;
      else if (drv_run != 0) begin
        chk("drive_len", 32'(drv_run), 32'(WP + 2));
        drv_run = 0;
      end
      if (!mem_we_n) begin
        we_run++;
        chk("pulse_data", 32'(mem_data), 32'(last_wdata));
        chk("pulse_ce", 32'(mem_ce_n), 32'd0);
      end else if (we_run != 0) begin
        chk("we_len", 32'(we_run), 32'(WP));
        we_run = 0;
      end
      if (req_ready) begin
        chk("idle_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'd7);
        chk("idle_bus", 32'(mem_data), 32'hFF);
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at cycle %0d", cyc);
        end else begin
          m_e = q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(m_e.rdata));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(m_e.timeout));
          if (m_e.lat >= 0) chk("rsp_latency", 32'(cyc - m_e.hs), 32'(m_e.lat));
          chk("ready_in_resp", 32'(req_ready), 32'd0);
        end
        last_rsp = rsp_rdata;
      end else begin
        chk("rdata_hold", 32'(rsp_rdata), 32'(last_rsp));
      end
    end
  end

  task automatic do_req(input logic wr, input logic [14:0] a, input logic [7:0] d,
                        input int lat, input logic to);
    exp_t e;
    int   w;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    w = 0;
    while (!req_ready && w < 600) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_accept: got req_ready=0 after %0d cycles expected 1", w);
      return;
    end
    e.rdata   = wr ? 8'h00 : ref_mem[a];
    e.timeout = to;
    e.lat     = lat;
    e.hs      = cyc;
    q.push_back(e);
    if (wr) begin
      ref_mem[a] = d;
      last_wdata = d;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d responses pending expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] a;
    logic [7:0]  saved;
    int          w;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_byte(i);
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'd7);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_bus", 32'(mem_data), 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    do_req(1'b0, 15'h1234, 8'h00, RD_LAT, 1'b0);
    idle(2);
    do_req(1'b1, 15'h0010, 8'h3C, WR_OK_LAT, 1'b0);
    idle(1);
    do_req(1'b0, 15'h0010, 8'h00, RD_LAT, 1'b0);
    idle(2);
    drain();

    // Back-to-back reads with req_valid held high.
    do_req(1'b0, 15'h1234, 8'h00, RD_LAT, 1'b0);
    do_req(1'b0, 15'h0010, 8'h00, RD_LAT, 1'b0);
    do_req(1'b0, 15'h7FFF, 8'h00, RD_LAT, 1'b0);
    idle(1);
    drain();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 15'($urandom_range(0, 7));
        1:       a = 15'h7FF8 + 15'($urandom_range(0, 7));
        2:       a = 15'h1234;
        default: a = 15'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1)
        do_req(1'b1, a, 8'($urandom_range(0, 254)), WR_OK_LAT, 1'b0);
      else
        do_req(1'b0, a, 8'h00, RD_LAT, 1'b0);
      w = $urandom_range(0, 2);
      if (w > 0) idle(w);
    end
    idle(1);
    drain();

`ifdef EEPROM_DATA_POLL_EN
    do_req(1'b1, 15'h0040, 8'h80, -1, 1'b0);
    idle(1);
    do_req(1'b0, 15'h0040, 8'h00, RD_LAT, 1'b0);
    idle(1);
    drain();
    stuck = 1'b1;
    do_req(1'b1, 15'h0041, 8'h80, WR_LAT, 1'b1);
    idle(1);
    drain();
    stuck = 1'b0;
`endif

    // Reset in the middle of the WE pulse: no response, location untouched.
    saved = ref_mem[15'h0020];
    do_req(1'b1, 15'h0020, 8'h5A, WR_OK_LAT, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (mem_we_n && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("reached_pulse", 32'(mem_we_n), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(mem_we_n), 32'd1);
    chk("mid_rst_strobes", 32'({mem_ce_n, mem_oe_n}), 32'd3);
    chk("mid_rst_bus", 32'(mem_data), 32'hFF);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp", 32'({rsp_valid, rsp_timeout}), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    q.delete();
    ref_mem[15'h0020] = saved;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_mid_rst", 32'(req_ready), 32'd1);
    repeat (30) @(negedge clk);

    do_req(1'b0, 15'h0020, 8'h00, RD_LAT, 1'b0);
    do_req(1'b0, 15'h0010, 8'h00, RD_LAT, 1'b0);
    idle(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
